cal_wrapped_phase: RTL and testbench
====================================

# cal_wrapped_phase

Computes the wrapped phase of every pixel from a four-step phase-shifted fringe set, PIPE_NUM pixels per beat, with modulation-based noise masking. Sits directly upstream of the absolute-phase unwrapping stage: each frequency's frame is streamed through it in turn, and its output stream is the per-frequency wrapped-phase input of that stage. The datapath is a fully pipelined CORDIC with a global stall and per-frame tlast passthrough.

## Interface
- PIPE_NUM, 8, pixels per beat
- PIX_W, 8, unsigned pixel width per step
- CORDIC_ITER, 14, CORDIC vectoring iterations (range 8..15)
- MOD_THRESH, 8, modulation threshold on |a|+|b|
- NOISE_CODE, 16'b10100000_00000000, output code for masked pixels

Ports:
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  reset; one clock; reset is synchronous and active-high
- s_axis_tdata  in  PIPE_NUM*4*PIX_W  pixel j, step k (k=0..3, shift k·π/2) at bits [(j*4+k)*PIX_W +: PIX_W]
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  last beat of a frame
- m_axis_tdata  out  PIPE_NUM*16  pixel j phase at [j*16 +: 16]
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  tlast of the corresponding input beat

## Operation
- Per pixel: a = I3 − I1, b = I0 − I2, signed PIX_W+1 bits; mod = |a| + |b|, unsigned PIX_W+1 bits.
- θ = atan2(a, b) mapped to [0, 2π); code = round(θ·32768/2π) mod 32768; bit 15 of every valid code is 0.
- If mod < MOD_THRESH, the output is NOISE_CODE (this includes a = b = 0).
- Pipeline stages (LAT = CORDIC_ITER + 3):
  - S0: register a, b, mod, valid, last.
  - S1: quadrant fold. If b < 0, rotate by π (x = −b, y = −a, z0 = π); otherwise z0 = 0. Use a PIX_W+4-bit guard-extended x/y.
  - S2..S(CORDIC_ITER+1): one vectoring iteration each (arctan(2^-i) ROM constants, z in 18-bit fraction-of-turn). No gain compensation; only the angle is used.
  - Final stage: wrap z to [0, 2π), round to 15 bits, apply noise substitution, then drive the output registers.
- Each pixel lane is independent. valid and last travel as sideband bits through all stages. Bubbles (invalid beats) propagate as invalid and are never emitted.
- Beat order is preserved exactly. Each output beat corresponds one-to-one with an accepted input beat.

## Timing
- Global stall: ce = ~m_axis_tvalid | m_axis_tready. All stage registers, including valid/last, update only when ce=1.
- s_axis_tready = ce & ~areset. This is a combinational path from m_axis_tready, by design.
- Latency: an input accepted on ce-cycle n appears on m_axis_t* after LAT cycles with ce=1.
- Without backpressure, throughput is 1 beat/cycle, sustained indefinitely.
- While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata/tlast hold stable and no input is accepted.
- Reset: all valid bits are 0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0. While areset=1, s_axis_tready=0. Asserting reset mid-frame discards all in-flight beats; the first cycle after reset deasserts is a clean start.
- Accuracy: |code − ideal| ≤ 2 LSB modulo 32768 (so 32767 vs 0 counts as 1 LSB) for every unmasked pixel.
- Simultaneous events: input acceptance and output emission occur in the same cycle whenever ce=1.

## Test plan
- Pixel steps (200,100,100,100): a=0, b=100. Expected code 0 ±2, with wrap tolerance around 32767.
- Steps (100,100,100,200): expected code 8192±2. Steps (100,100,200,100): expected 16384±2. Steps (100,200,100,100): expected 24576±2.
- All four steps = 77, and a case with mod = MOD_THRESH−1: expected NOISE_CODE 0xA000. A case with mod = MOD_THRESH: expected a phase code, not NOISE_CODE.
- Random 10k beats against a double-precision model, with random m_axis_tready (50% duty) and random s_axis_tvalid gaps. Required: zero dropped or duplicated beats, in-order delivery, all codes within ±2 LSB, and tlast on exactly the beats whose inputs carried it.
- Hold m_axis_tready=0 for 40 cycles mid-stream. Required: output data stable throughout, s_axis_tready=0 throughout, and after release the stream continues with no loss.
- Assert areset for 1 cycle with LAT beats in flight. Required: m_axis_tvalid=0 on the next cycle, no stale beats emitted afterwards, and the first post-reset input emerges after exactly LAT cycles.

Source files
------------

// File: rtl/cal_wrapped_phase.sv
// cal_wrapped_phase: wrapped phase from a four-step fringe set, PIPE_NUM lanes per beat.
// Fully pipelined CORDIC vectoring with modulation masking and a global stall.
module cal_wrapped_phase #(
    parameter int          PIPE_NUM    = 8,
    parameter int          PIX_W       = 8,
    parameter int          CORDIC_ITER = 14,
    parameter int          MOD_THRESH  = 8,
    parameter logic [15:0] NOISE_CODE  = 16'b10100000_00000000
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [PIPE_NUM*4*PIX_W-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    output logic [PIPE_NUM*16-1:0]      m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast
);

    localparam int LAT  = CORDIC_ITER + 3;
    localparam int DW   = PIX_W + 1;
    // Integer part is PIX_W+4 bits so the CORDIC gain never overflows;
    // the fraction keeps shift truncation well below one output LSB
    // even for the weakest unmasked vectors.
    localparam int FRAC = 16;
    localparam int XW   = PIX_W + 4 + FRAC;
    localparam int ZW   = 18;

    typedef logic signed [DW-1:0] dif_t;
    typedef logic signed [XW-1:0] xy_t;
    typedef logic [ZW-1:0]        ang_t;

    // atan(2^-i) in units of 2^-18 turn
    function automatic ang_t atan_rom(input int i);
        ang_t r;
        case (i)
            0:       r = ang_t'(32768);
            1:       r = ang_t'(19344);
            2:       r = ang_t'(10221);
            3:       r = ang_t'(5188);
            4:       r = ang_t'(2604);
            5:       r = ang_t'(1303);
            6:       r = ang_t'(652);
            7:       r = ang_t'(326);
            8:       r = ang_t'(163);
            9:       r = ang_t'(81);
            10:      r = ang_t'(41);
            11:      r = ang_t'(20);
            12:      r = ang_t'(10);
            13:      r = ang_t'(5);
            14:      r = ang_t'(3);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [DW-1:0] mag(input dif_t v);
        return v[DW-1] ? DW'(-v) : DW'(v);
    endfunction

    // Round an 18-bit turn fraction to 15 bits; the sum wraps modulo one turn.
    function automatic logic [14:0] rnd15(input ang_t z);
        ang_t t;
        t = z + ang_t'(4);
        return t[ZW-1:ZW-15];
    endfunction

    logic ce;

    dif_t          a_q   [PIPE_NUM];
    dif_t          a_d   [PIPE_NUM];
    dif_t          b_q   [PIPE_NUM];
    dif_t          b_d   [PIPE_NUM];
    logic [DW-1:0] mod_q [PIPE_NUM];
    logic [DW-1:0] mod_d [PIPE_NUM];

    xy_t  x_q   [PIPE_NUM][CORDIC_ITER-1];
    xy_t  x_d   [PIPE_NUM][CORDIC_ITER-1];
    xy_t  y_q   [PIPE_NUM][CORDIC_ITER];
    xy_t  y_d   [PIPE_NUM][CORDIC_ITER];
    ang_t z_q   [PIPE_NUM][CORDIC_ITER+1];
    ang_t z_d   [PIPE_NUM][CORDIC_ITER+1];
    logic msk_q [PIPE_NUM][CORDIC_ITER+1];
    logic msk_d [PIPE_NUM][CORDIC_ITER+1];

    logic [LAT-1:0]         vld_q, vld_d;
    logic [LAT-1:0]         lst_q, lst_d;
    logic [PIPE_NUM*16-1:0] dat_q, dat_d;

    assign m_axis_tvalid = vld_q[LAT-1];
    assign m_axis_tlast  = lst_q[LAT-1];
    assign m_axis_tdata  = dat_q;
    assign ce            = ~m_axis_tvalid | m_axis_tready;
    assign s_axis_tready = ce & ~areset;

    // Next state of every pipeline stage for all lanes.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        mod_d = mod_q;
        x_d   = x_q;
        y_d   = y_q;
        z_d   = z_q;
        msk_d = msk_q;
        dat_d = dat_q;
        vld_d = {vld_q[LAT-2:0], s_axis_tvalid};
        lst_d = {lst_q[LAT-2:0], s_axis_tvalid & s_axis_tlast};
        for (int j = 0; j < PIPE_NUM; j++) begin
            a_d[j] = dif_t'({1'b0, s_axis_tdata[(j*4+3)*PIX_W +: PIX_W]})
                   - dif_t'({1'b0, s_axis_tdata[(j*4+1)*PIX_W +: PIX_W]});
            b_d[j] = dif_t'({1'b0, s_axis_tdata[(j*4+0)*PIX_W +: PIX_W]})
                   - dif_t'({1'b0, s_axis_tdata[(j*4+2)*PIX_W +: PIX_W]});
            mod_d[j] = mag(a_d[j]) + mag(b_d[j]);

            // fold the left half-plane onto the right one
            if (b_q[j][DW-1]) begin
                x_d[j][0] = -(xy_t'(b_q[j]) <<< FRAC);
                y_d[j][0] = -(xy_t'(a_q[j]) <<< FRAC);
                z_d[j][0] = ang_t'(1) << (ZW - 1);
            end else begin
                x_d[j][0] = xy_t'(b_q[j]) <<< FRAC;
                y_d[j][0] = xy_t'(a_q[j]) <<< FRAC;
                z_d[j][0] = '0;
            end
            msk_d[j][0] = mod_q[j] < DW'(MOD_THRESH);

            for (int k = 0; k < CORDIC_ITER; k++) begin
                if (!y_q[j][k][XW-1]) begin
                    z_d[j][k+1] = z_q[j][k] + atan_rom(k);
                end else begin
                    z_d[j][k+1] = z_q[j][k] - atan_rom(k);
                end
                msk_d[j][k+1] = msk_q[j][k];
            end
            for (int k = 0; k < CORDIC_ITER - 1; k++) begin
                if (!y_q[j][k][XW-1]) begin
                    y_d[j][k+1] = y_q[j][k] - (x_q[j][k] >>> k);
                end else begin
                    y_d[j][k+1] = y_q[j][k] + (x_q[j][k] >>> k);
                end
            end
            for (int k = 0; k < CORDIC_ITER - 2; k++) begin
                if (!y_q[j][k][XW-1]) begin
                    x_d[j][k+1] = x_q[j][k] + (y_q[j][k] >>> k);
                end else begin
                    x_d[j][k+1] = x_q[j][k] - (y_q[j][k] >>> k);
                end
            end

            dat_d[j*16 +: 16] = msk_q[j][CORDIC_ITER] ? NOISE_CODE
                              : {1'b0, rnd15(z_q[j][CORDIC_ITER])};
        end
    end

    // Sideband and output registers: cleared by reset, advanced on ce.
    always_ff @(posedge aclk) begin
        if (areset) begin
            vld_q <= '0;
            lst_q <= '0;
            dat_q <= '0;
        end else if (ce) begin
            vld_q <= vld_d;
            lst_q <= lst_d;
            dat_q <= dat_d;
        end
    end

    // Datapath registers: qualified by the valid sideband, so no reset.
    always_ff @(posedge aclk) begin
        if (ce) begin
            a_q   <= a_d;
            b_q   <= b_d;
            mod_q <= mod_d;
            x_q   <= x_d;
            y_q   <= y_d;
            z_q   <= z_d;
            msk_q <= msk_d;
        end
    end

endmodule

// File: tb/tb_cal_wrapped_phase.sv
// tb_cal_wrapped_phase: random and directed stimulus, queue scoreboard
// against an atan2-based reference.
module tb_cal_wrapped_phase;

    localparam int  PN     = 8;
    localparam int  PW     = 8;
    localparam int  CI     = 14;
    localparam int  LAT    = CI + 3;
    localparam int  DW     = PN * 4 * PW;
    localparam int  SC     = 1024;
    localparam real TWO_PI = 6.283185307179586;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic [PN*16-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;

    int total = 0;
    int bad   = 0;
    int mode  = 1;
    int nb    = 0;

    typedef struct {
        int ph [PN];
        bit lst;
    } exp_t;

    exp_t sbq [$];
    exp_t mon_e;
    exp_t cur_e;
    logic [DW-1:0] cur_d;

    int dir [PN][4] = '{'{200, 100, 100, 100}, '{100, 100, 100, 200},
                        '{100, 100, 200, 100}, '{100, 200, 100, 100},
                        '{77, 77, 77, 77},     '{100, 100, 100, 107},
                        '{100, 100, 100, 108}, '{100, 104, 104, 100}};
    int dir_ph [PN] = '{0, 8192*SC, 16384*SC, 24576*SC,
                        -1, -1, 8192*SC, 20480*SC};

    cal_wrapped_phase dut (
        .aclk          (clk),
        .areset        (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Downstream ready: 0 random, 1 always ready, 2 held off.
    always @(posedge clk) begin
        #2;
        case (mode)
            0:       m_tready = ($urandom_range(0, 1) == 1);
            1:       m_tready = 1'b1;
            default: m_tready = 1'b0;
        endcase
    end

    task automatic chk(input string nm, input logic [159:0] act,
                       input logic [159:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // Ideal code scaled by SC, or -1 where the pixel must be masked.
    function automatic int model(input int i0, input int i1,
                                 input int i2, input int i3);
        int  a;
        int  b;
        real t;
        a = i3 - i1;
        b = i0 - i2;
        if ((a < 0 ? -a : a) + (b < 0 ? -b : b) < 8) return -1;
        t = $atan2(real'(a), real'(b));
        if (t < 0.0) t = t + TWO_PI;
        return $rtoi(t / TWO_PI * 32768.0 * SC + 0.5);
    endfunction

    function automatic bit lane_ok(input int ph, input logic [15:0] act);
        longint d;
        if (ph < 0) return act == 16'hA000;
        if (act[15]) return 1'b0;
        d = longint'(act) * SC - ph;
        while (d > 16384 * SC) d = d - 32768 * SC;
        while (d <= -16384 * SC) d = d + 32768 * SC;
        return (d <= 2 * SC) && (d >= -2 * SC);
    endfunction

    // Scoreboard monitor: pop and compare on every output transfer.
    always @(negedge clk) begin
        if (!areset && m_tvalid && m_tready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_beat: got beat %0d want none", nb);
            end else begin
                mon_e = sbq.pop_front();
                for (int j = 0; j < PN; j++) begin
                    total++;
                    if (!lane_ok(mon_e.ph[j], m_tdata[j*16 +: 16])) begin
                        bad++;
                        $display("FAIL phase lane=%0d beat=%0d got=%0d want=%0d/1024 (-1 means noise)",
                                 j, nb, m_tdata[j*16 +: 16], mon_e.ph[j]);
                    end
                end
                total++;
                if (m_tlast !== mon_e.lst) begin
                    bad++;
                    $display("FAIL tlast beat=%0d got=%0b want=%0b",
                             nb, m_tlast, mon_e.lst);
                end
            end
            nb++;
        end
    end

    task automatic rand_beat(output logic [DW-1:0] d, output exp_t e);
        int p [4];
        int base;
        d = '0;
        for (int j = 0; j < PN; j++) begin
            if ($urandom_range(0, 7) == 0) begin
                base = int'($urandom_range(10, 240));
                for (int k = 0; k < 4; k++)
                    p[k] = base + int'($urandom_range(0, 6)) - 3;
            end else begin
                for (int k = 0; k < 4; k++)
                    p[k] = int'($urandom_range(0, 255));
            end
            for (int k = 0; k < 4; k++)
                d[(j*4+k)*PW +: PW] = PW'(p[k]);
            e.ph[j] = model(p[0], p[1], p[2], p[3]);
        end
        e.lst = ($urandom_range(0, 15) == 0);
    endtask

    // Present one beat; its expectation is queued on the accepting edge.
    task automatic send(input logic [DW-1:0] d, input exp_t e);
        int w;
        w = 0;
        s_tdata  = d;
        s_tlast  = e.lst;
        s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_tready) begin
                sbq.push_back(e);
                @(posedge clk);
                #1;
                break;
            end
            w++;
            if (w > 2000) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got no s_tready want accept");
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 4000) begin
            @(posedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        chk(nm, sbq.size(), 0);
    endtask

    initial begin
        logic [PN*16+1:0] hd;
        int n;

        areset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata", m_tdata, 0);
        @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        chk("run_s_tready", s_tready, 1);
        @(posedge clk);
        #1;

        for (int j = 0; j < PN; j++) begin
            for (int k = 0; k < 4; k++)
                cur_d[(j*4+k)*PW +: PW] = PW'(dir[j][k]);
            cur_e.ph[j] = dir_ph[j];
        end
        cur_e.lst = 1'b1;
        send(cur_d, cur_e);
        drain("drain_directed");

        mode = 0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            rand_beat(cur_d, cur_e);
            send(cur_d, cur_e);
        end
        mode = 1;
        drain("drain_random");

        for (int i = 0; i < LAT + 4; i++) begin
            rand_beat(cur_d, cur_e);
            send(cur_d, cur_e);
        end
        mode = 2;
        rand_beat(cur_d, cur_e);
        s_tdata  = cur_d;
        s_tlast  = cur_e.lst;
        s_tvalid = 1'b1;
        @(negedge clk);
        hd = {m_tvalid, m_tlast, m_tdata};
        chk("stall_valid", m_tvalid, 1);
        repeat (40) begin
            @(negedge clk);
            chk("stall_hold", {m_tvalid, m_tlast, m_tdata}, hd);
            chk("stall_s_tready", s_tready, 0);
        end
        @(posedge clk);
        #1;
        mode = 1;
        send(cur_d, cur_e);
        for (int i = 0; i < 8; i++) begin
            rand_beat(cur_d, cur_e);
            send(cur_d, cur_e);
        end
        drain("drain_stall");

        idle(4);
        for (int i = 0; i < LAT; i++) begin
            rand_beat(cur_d, cur_e);
            send(cur_d, cur_e);
        end
        mode   = 2;
        areset = 1'b1;
        @(negedge clk);
        chk("midrst_s_tready", s_tready, 0);
        @(posedge clk);
        #1;
        areset = 1'b0;
        sbq.delete();
        mode = 1;
        @(negedge clk);
        chk("postrst_m_tvalid", m_tvalid, 0);
        @(posedge clk);
        #1;
        rand_beat(cur_d, cur_e);
        send(cur_d, cur_e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_tvalid && n < 100);
        chk("postrst_latency", n, LAT);
        @(posedge clk);
        #1;
        drain("drain_reset");

        idle(30);
        @(negedge clk);
        chk("final_idle", m_tvalid, 0);
        chk("final_queue", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
